// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file with stack-pointer support.
// Default sizes, SP bounds, and the encoded SP-operation priority result.
package regfile_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_REGS = 4;

    localparam logic [DEF_DATA_W-1:0] DEF_SP_RESET = 8'hFF;
    localparam logic [DEF_DATA_W-1:0] DEF_SP_LIMIT = 8'h00;

    typedef enum logic [1:0] {
        SP_NOP  = 2'd0,
        SP_PUSH = 2'd1,
        SP_POP  = 2'd2,
        SP_HOLD = 2'd3
    } sp_op_e;

    // A write-port hit or a simultaneous push/pop freezes the SP arithmetic.
    function automatic sp_op_e sp_op_decode(input logic wr_hit, input logic push, input logic pop);
        sp_op_e op;
        if (wr_hit || (push && pop)) begin
            op = SP_HOLD;
        end else if (push) begin
            op = SP_PUSH;
        end else if (pop) begin
            op = SP_POP;
        end else begin
            op = SP_NOP;
        end
        return op;
    endfunction

endpackage

// File: rtl/regfile_sp_param_sp_ctrl.sv
// Stack-pointer next-state logic: saturating push/pop and sticky overflow/underflow flags.
// Purely combinational; the owning register file holds SP and the flags.
module sp_ctrl
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_LIMIT = {DATA_W{1'b0}}
) (
    input  logic [DATA_W-1:0] sp_cur_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              wr_hit_i,
    input  logic              ovf_i,
    input  logic              unf_i,
    input  logic              flag_clr_i,
    output logic [DATA_W-1:0] sp_next_o,
    output logic              ovf_next_o,
    output logic              unf_next_o,
    output logic              sp_wr_sel_o
);

    sp_op_e sp_op_s;
    logic   ovf_ev_s;
    logic   unf_ev_s;

    // Saturating SP arithmetic; an attempt past either bound raises a flag event instead.
    always_comb begin
        sp_op_s   = sp_op_decode(wr_hit_i, push_i, pop_i);
        sp_next_o = sp_cur_i;
        ovf_ev_s  = 1'b0;
        unf_ev_s  = 1'b0;
        case (sp_op_s)
            SP_PUSH: begin
                if (sp_cur_i != SP_LIMIT) begin
                    sp_next_o = sp_cur_i - DATA_W'(1'b1);
                end else begin
                    ovf_ev_s = 1'b1;
                end
            end
            SP_POP: begin
                if (sp_cur_i != SP_RESET) begin
                    sp_next_o = sp_cur_i + DATA_W'(1'b1);
                end else begin
                    unf_ev_s = 1'b1;
                end
            end
            SP_HOLD: sp_next_o = sp_cur_i;
            SP_NOP:  sp_next_o = sp_cur_i;
            default: sp_next_o = sp_cur_i;
        endcase
    end

    // A new event beats a same-cycle clear so no overflow/underflow is ever lost.
    always_comb begin
        ovf_next_o  = ovf_ev_s | (ovf_i & ~flag_clr_i);
        unf_next_o  = unf_ev_s | (unf_i & ~flag_clr_i);
        sp_wr_sel_o = wr_hit_i;
    end

endmodule

// File: rtl/regfile_sp_param.sv
// Register file: one sync write port, two async read ports, one register acting as stack pointer.
// Define REGFILE_WR_BYPASS_EN to forward write data to same-cycle reads of the write target.
module regfile_sp_param
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter int                SP_IDX   = NUM_REGS - 1,
    parameter logic [DATA_W-1:0] SP_RESET = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] SP_LIMIT = {DATA_W{1'b0}},
    localparam int               ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wenabel,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] ra_date,
    output logic [DATA_W-1:0] rb_date,
    input  logic              sp_push,
    input  logic              sp_pop,
    input  logic              flag_clr,
    output logic [DATA_W-1:0] sp_value,
    output logic              sp_ovf,
    output logic              sp_unf
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              ovf_q;
    logic              ovf_d;
    logic              unf_q;
    logic              unf_d;

    logic              wr_hit_s;
    logic [DATA_W-1:0] sp_arith_s;
    logic              sp_wr_sel_s;
    logic [DATA_W-1:0] sp_next_s;

    assign wr_hit_s = wenabel && (rd == ADDR_W'(SP_IDX));

    sp_ctrl #(
        .DATA_W   (DATA_W),
        .SP_RESET (SP_RESET),
        .SP_LIMIT (SP_LIMIT)
    ) u_sp_ctrl (
        .sp_cur_i    (regs_q[SP_IDX]),
        .push_i      (sp_push),
        .pop_i       (sp_pop),
        .wr_hit_i    (wr_hit_s),
        .ovf_i       (ovf_q),
        .unf_i       (unf_q),
        .flag_clr_i  (flag_clr),
        .sp_next_o   (sp_arith_s),
        .ovf_next_o  (ovf_d),
        .unf_next_o  (unf_d),
        .sp_wr_sel_o (sp_wr_sel_s)
    );

    // Next storage contents: write port for ordinary registers, SP gets write data or its arithmetic result.
    always_comb begin
        regs_d = regs_q;
        if (wenabel) begin
            regs_d[rd] = write_data;
        end else begin
            regs_d[rd] = regs_q[rd];
        end
        if (sp_wr_sel_s) begin
            sp_next_s = write_data;
        end else begin
            sp_next_s = sp_arith_s;
        end
        regs_d[SP_IDX] = sp_next_s;
    end

    // Storage and sticky flags; reset overrides any same-cycle write or SP operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i == SP_IDX) begin
                    regs_q[i] <= SP_RESET;
                end else begin
                    regs_q[i] <= {DATA_W{1'b0}};
                end
            end
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Asynchronous read muxes; SP push/pop results are never forwarded.
    always_comb begin
        ra_date = regs_q[ra];
        rb_date = regs_q[rb];
`ifdef REGFILE_WR_BYPASS_EN
        if (wenabel && (rd == ra)) begin
            ra_date = write_data;
        end else begin
            ra_date = regs_q[ra];
        end
        if (wenabel && (rd == rb)) begin
            rb_date = write_data;
        end else begin
            rb_date = regs_q[rb];
        end
`endif
    end

    assign sp_value = regs_q[SP_IDX];
    assign sp_ovf   = ovf_q;
    assign sp_unf   = unf_q;

endmodule

// File: tb/tb_regfile_sp_param.sv
// Self-checking bench for regfile_sp_param (default parameters): a behavioural model checked
// every negedge, plus directed vectors with hand-computed literal expectations.
module tb_regfile_sp_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wenabel;
    logic [1:0] rd;
    logic [7:0] write_data;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] ra_date;
    logic [7:0] rb_date;
    logic       sp_push;
    logic       sp_pop;
    logic       flag_clr;
    logic [7:0] sp_value;
    logic       sp_ovf;
    logic       sp_unf;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: register contents and flags as plain variables.
    int  m_r [4];
    int  m_ovf;
    int  m_unf;
    bit  model_valid = 1'b0;

    regfile_sp_param dut (
        .clk        (clk),
        .rst        (rst),
        .wenabel    (wenabel),
        .rd         (rd),
        .write_data (write_data),
        .ra         (ra),
        .rb         (rb),
        .ra_date    (ra_date),
        .rb_date    (rb_date),
        .sp_push    (sp_push),
        .sp_pop     (sp_pop),
        .flag_clr   (flag_clr),
        .sp_value   (sp_value),
        .sp_ovf     (sp_ovf),
        .sp_unf     (sp_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_read(input int addr);
`ifdef REGFILE_WR_BYPASS_EN
        if (wenabel === 1'b1 && int'(rd) == addr) return int'(write_data);
`endif
        return m_r[addr];
    endfunction

    // Apply the specification's rules to the model at a clock edge.
    task automatic model_step();
        int sp;
        int ovf_ev;
        int unf_ev;
        if (rst) begin
            m_r = '{0, 0, 0, 255};
            m_ovf = 0;
            m_unf = 0;
            return;
        end
        sp = m_r[3];
        ovf_ev = 0;
        unf_ev = 0;
        if (wenabel) m_r[rd] = int'(write_data);
        if (!(wenabel && rd == 2'd3) && !(sp_push && sp_pop)) begin
            if (sp_push) begin
                if (sp == 0) ovf_ev = 1; else m_r[3] = sp - 1;
            end else if (sp_pop) begin
                if (sp == 255) unf_ev = 1; else m_r[3] = sp + 1;
            end
        end
        if (flag_clr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (ovf_ev != 0) m_ovf = 1;
        if (unf_ev != 0) m_unf = 1;
    endtask

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("ra_date",  int'(ra_date),  exp_read(int'(ra)));
            check("rb_date",  int'(rb_date),  exp_read(int'(rb)));
            check("sp_value", int'(sp_value), m_r[3]);
            check("sp_ovf",   int'(sp_ovf),   m_ovf);
            check("sp_unf",   int'(sp_unf),   m_unf);
        end
    end

    task automatic drive(input logic w, input logic [1:0] d, input logic [7:0] wd,
                         input logic pu, input logic po, input logic clr);
        wenabel    = w;
        rd         = d;
        write_data = wd;
        sp_push    = pu;
        sp_pop     = po;
        flag_clr   = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        model_valid = 1'b1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ra  = 2'd0;
        rb  = 2'd0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;

        // 1. Reset state, and reset overriding a write
        tick();
        rst = 1'b0;
        check("rst_sp", int'(sp_value), 8'hFF);
        check("rst_ovf", int'(sp_ovf), 0);
        check("rst_unf", int'(sp_unf), 0);
        for (int i = 0; i < 3; i++) begin
            ra = 2'(i);
            rb = 2'd3;
            #1;
            check("rst_reg", int'(ra_date), 8'h00);
            check("rst_r3", int'(rb_date), 8'hFF);
        end
        rst = 1'b1;
        drive(1'b1, 2'd1, 8'h55, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        ra = 2'd1;
        #1;
        check("rst_wins_write", int'(ra_date), 8'h00);
        check("rst_wins_push", int'(sp_value), 8'hFF);

        // 2. Write then read on both ports
        drive(1'b1, 2'd2, 8'hA5, 1'b0, 1'b0, 1'b0);
        ra = 2'd2;
        #1;
`ifdef REGFILE_WR_BYPASS_EN
        check("same_cycle_read", int'(ra_date), 8'hA5);
`else
        check("same_cycle_read", int'(ra_date), 8'h00);
`endif
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        ra = 2'd2;
        rb = 2'd2;
        #1;
        check("read_a", int'(ra_date), 8'hA5);
        check("read_b", int'(rb_date), 8'hA5);

        // 3. Push / pop
        do_reset();
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        check("push3", int'(sp_value), 8'hFC);
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        tick();
        check("push_pop", int'(sp_value), 8'hFC);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        check("pop1", int'(sp_value), 8'hFD);

        // 4. Underflow and clear priority
        do_reset();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        check("unf_sp", int'(sp_value), 8'hFF);
        check("unf_set", int'(sp_unf), 1);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        check("unf_clr", int'(sp_unf), 0);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        tick();
        check("unf_event_beats_clr", int'(sp_unf), 1);

        // 5. Overflow, sticky across idle cycles
        do_reset();
        drive(1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        check("ovf_sp", int'(sp_value), 8'h00);
        check("ovf_set", int'(sp_ovf), 1);
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        check("ovf_sticky", int'(sp_ovf), 1);
        check("ovf_no_unf", int'(sp_unf), 0);

        // 6. Write-port priority over push; non-SP write alongside push
        do_reset();
        drive(1'b1, 2'd3, 8'h80, 1'b1, 1'b0, 1'b0);
        tick();
        check("wr_beats_push", int'(sp_value), 8'h80);
        check("wr_no_ovf", int'(sp_ovf), 0);
        drive(1'b1, 2'd0, 8'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        ra = 2'd0;
        #1;
        check("r0_written", int'(ra_date), 8'h3C);
        check("sp_dec_with_wr", int'(sp_value), 8'h7F);
        drive(1'b1, 2'd3, 8'hFF, 1'b0, 1'b1, 1'b0);
        tick();
        check("wr_beats_pop_no_unf", int'(sp_unf), 0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 40; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(($urandom_range(0, 7)) == 0));
            ra = 2'($urandom_range(0, 3));
            rb = 2'($urandom_range(0, 3));
            tick();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
